// File: rtl/lsu_mem_stage_if.sv
// -----------------------------------------------------------------------------
// lsu_mem_stage_if
// Bundles every non-clock signal of the load/store unit.
//   req_*  : request from the memory-stage datapath (valid/ready)
//   resp_* : response back to the datapath (valid/ready)
//   mem_*  : port to the 64-word, word-addressed data memory
//            (combinational read data, single full-word write enable)
// Modports:
//   slave  : the load/store unit itself
//   master : its environment (datapath + data memory)
// -----------------------------------------------------------------------------
interface lsu_mem_stage_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  resp_ready, mem_rd,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_a, mem_wd, mem_we
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output resp_ready, mem_rd,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_a, mem_wd, mem_we
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// -----------------------------------------------------------------------------
// lsu_mem_stage
// Load/store unit between the memory-stage datapath and a word-addressed data
// memory. Adds byte/halfword/word loads (sign- or zero-extended) and stores;
// sub-word stores are done as read-modify-write. Misaligned, illegal-size and
// out-of-range requests are answered with resp_err and never touch memory.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : lsu_mem_stage_if.slave (request, response and memory signals)
// At most one request is outstanding: req_ready is only high in IDLE.
// -----------------------------------------------------------------------------
module lsu_mem_stage #(
  parameter int MEM_WORDS = 64
) (
  input  logic          clk,
  input  logic          reset,
  lsu_mem_stage_if.slave bus
);

  localparam logic [29:0] LP_MEM_WORDS = 30'(MEM_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WRITE,
    S_RESP
  } state_t;

  state_t      r_state,    w_state_next;
  logic        r_we,       w_we_next;
  logic [1:0]  r_size,     w_size_next;
  logic        r_unsigned, w_unsigned_next;
  logic [31:0] r_addr,     w_addr_next;
  logic [31:0] r_wdata,    w_wdata_next;
  logic [31:0] r_rdata,    w_rdata_next;
  logic        r_err,      w_err_next;
  logic [31:0] r_merge,    w_merge_next;

  logic        w_req_err;
  logic [3:0][7:0] w_rd_bytes;
  logic [31:0] w_sb_word;
  logic [31:0] w_sh_word;
  logic [7:0]  w_byte_sel;
  logic [15:0] w_half_sel;
  logic [31:0] w_load_data;
  logic        w_mem_we;
  logic [31:0] w_mem_wd;

  // Request check is done on the live request so an error can go straight to
  // RESP in the acceptance cycle.
  assign w_req_err = (bus.req_size == 2'b11)
                   | ((bus.req_size == 2'b01) & bus.req_addr[0])
                   | ((bus.req_size == 2'b10) & (bus.req_addr[1:0] != 2'b00))
                   | (bus.req_addr[31:2] >= LP_MEM_WORDS);

  // Per-lane view of the read word and the two possible merged store words.
  // Lane gi is bits [8*gi+7:8*gi] (little-endian).
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_rd_bytes[gi] = bus.mem_rd[8*gi +: 8];
      assign w_sb_word[8*gi +: 8] = (r_addr[1:0] == 2'(gi)) ? r_wdata[7:0]
                                                            : w_rd_bytes[gi];
      assign w_sh_word[8*gi +: 8] = (r_addr[1] == 1'(gi / 2))
                                  ? r_wdata[8*(gi % 2) +: 8]
                                  : w_rd_bytes[gi];
    end
  endgenerate

  assign w_byte_sel = w_rd_bytes[r_addr[1:0]];
  assign w_half_sel = r_addr[1] ? bus.mem_rd[31:16] : bus.mem_rd[15:0];

  always_comb begin
    w_load_data = bus.mem_rd;
    case (r_size)
      2'b00:   w_load_data = {{24{~r_unsigned & w_byte_sel[7]}}, w_byte_sel};
      2'b01:   w_load_data = {{16{~r_unsigned & w_half_sel[15]}}, w_half_sel};
      default: w_load_data = bus.mem_rd;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_merge    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_we       <= w_we_next;
      r_size     <= w_size_next;
      r_unsigned <= w_unsigned_next;
      r_addr     <= w_addr_next;
      r_wdata    <= w_wdata_next;
      r_rdata    <= w_rdata_next;
      r_err      <= w_err_next;
      r_merge    <= w_merge_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_we_next       = r_we;
    w_size_next     = r_size;
    w_unsigned_next = r_unsigned;
    w_addr_next     = r_addr;
    w_wdata_next    = r_wdata;
    w_rdata_next    = r_rdata;
    w_err_next      = r_err;
    w_merge_next    = r_merge;
    w_mem_we        = 1'b0;
    w_mem_wd        = '0;

    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          w_we_next       = bus.req_we;
          w_size_next     = bus.req_size;
          w_unsigned_next = bus.req_unsigned;
          w_addr_next     = bus.req_addr;
          w_wdata_next    = bus.req_wdata;
          if (w_req_err) begin
            w_err_next   = 1'b1;
            w_rdata_next = '0;
            w_state_next = S_RESP;
          end else begin
            w_err_next   = 1'b0;
            w_state_next = S_ACCESS;
          end
        end
      end

      S_ACCESS: begin
        if (!r_we) begin
          w_rdata_next = w_load_data;
          w_state_next = S_RESP;
        end else if (r_size == 2'b10) begin
          w_mem_we     = 1'b1;
          w_mem_wd     = r_wdata;
          w_rdata_next = '0;
          w_state_next = S_RESP;
        end else begin
          // Sub-word store: capture the merged word now, write it next cycle.
          w_merge_next = (r_size == 2'b00) ? w_sb_word : w_sh_word;
          w_state_next = S_WRITE;
        end
      end

      S_WRITE: begin
        w_mem_we     = 1'b1;
        w_mem_wd     = r_merge;
        w_rdata_next = '0;
        w_state_next = S_RESP;
      end

      S_RESP: begin
        if (bus.resp_ready) begin
          w_state_next = S_IDLE;
        end
      end

      default: w_state_next = S_IDLE;
    endcase
  end

  // Reset gates the write strobe combinationally so an aborted store can
  // never reach memory, even in its WRITE cycle.
  assign bus.mem_we     = w_mem_we & ~reset;
  assign bus.mem_wd     = reset ? 32'h0 : w_mem_wd;
  assign bus.mem_a      = {r_addr[31:2], 2'b00};
  assign bus.req_ready  = (r_state == S_IDLE) & ~reset;
  assign bus.resp_valid = (r_state == S_RESP);
  assign bus.resp_err   = r_err & (r_state == S_RESP);
  assign bus.resp_rdata = r_rdata;

endmodule

// File: tb/tb_lsu_mem_stage.sv
module tb_lsu_mem_stage;
  logic clk;
  logic reset;
  lsu_mem_stage_if bus();

  lsu_mem_stage #(.MEM_WORDS(64)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory used by the DUT, plus a backdoor for preloading.
  logic [31:0] tb_mem [64];
  logic        bd_we;
  logic [5:0]  bd_idx;
  logic [31:0] bd_data;
  assign bus.mem_rd = tb_mem[bus.mem_a[7:2]];
  always @(posedge clk) begin
    if (bd_we) tb_mem[bd_idx] <= bd_data;
    else if (bus.mem_we) tb_mem[bus.mem_a[7:2]] <= bus.mem_wd;
  end

  // Reference memory image maintained by the model.
  logic [31:0] ref_mem [64];

  int n_checks = 0;
  int n_fail   = 0;

  // Results of the last transaction.
  int          t_lat, t_nwr, t_wcyc;
  logic [31:0] t_rdata, t_wdata, t_prev_rd;
  logic        t_err, t_held_ok, t_rdy_before;

  // Model outputs.
  int          m_lat, m_nwr, m_wcyc;
  logic [31:0] m_rdata, m_wword;
  logic        m_err;

  function automatic void model(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata);
    int nbytes, sh;
    logic [31:0] word, mask, val;
    m_err = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
            (size == 2'd2 && addr[1:0] != 2'd0) || (addr[31:2] >= 30'd64);
    m_rdata = 0; m_nwr = 0; m_wcyc = 0; m_wword = 0; m_lat = 1;
    if (m_err) return;
    nbytes = 1 << size;
    sh     = 8 * int'(addr[1:0]);
    mask   = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
    word   = ref_mem[addr[7:2]];
    if (!we) begin
      val = (word >> sh) & mask;
      if (!uns && val[8*nbytes-1]) val = val | ~mask;
      m_rdata = val;
      m_lat   = 2;
    end else begin
      m_wword = (word & ~(mask << sh)) | ((wdata & mask) << sh);
      ref_mem[addr[7:2]] = m_wword;
      m_nwr  = 1;
      m_lat  = (nbytes == 4) ? 2 : 3;
      m_wcyc = m_lat - 1;
    end
  endfunction

  task automatic backdoor(input int idx, input logic [31:0] data);
    @(negedge clk);
    bd_we = 1'b1; bd_idx = 6'(idx); bd_data = data;
    @(posedge clk);
    #1 bd_we = 1'b0;
    ref_mem[idx] = data;
  endtask

  // Drives one request, records latency, writes and response; returns just
  // after the response handshake edge.
  task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input int stall);
    @(negedge clk);
    t_rdy_before = bus.req_ready & ~bus.resp_valid;
    t_prev_rd    = bus.resp_rdata;
    bus.resp_ready   = 1'b0;
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'($urandom);
    bus.req_size     = 2'($urandom);
    bus.req_unsigned = 1'($urandom);
    bus.req_addr     = $urandom;
    bus.req_wdata    = $urandom;
    t_lat = 0; t_nwr = 0; t_wcyc = 0; t_wdata = 0;
    for (int k = 1; k <= 8; k++) begin
      if (bus.mem_we) begin t_nwr++; t_wcyc = k; t_wdata = bus.mem_wd; end
      if (bus.resp_valid) begin t_lat = k; break; end
      @(negedge clk);
    end
    t_rdata = bus.resp_rdata;
    t_err   = bus.resp_err;
    t_held_ok = 1'b1;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== t_rdata || bus.resp_err !== t_err ||
          bus.req_ready !== 1'b0 || bus.mem_we !== 1'b0) t_held_ok = 1'b0;
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready got %0b want 0", bus.req_ready); end
    n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got %0b want 0", bus.resp_valid); end
    n_checks++; if (bus.resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_resp_err got %0b want 0", bus.resp_err); end
    n_checks++; if (bus.resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_resp_rdata got %h want 0", bus.resp_rdata); end
    n_checks++; if (bus.mem_a !== 32'h0) begin n_fail++; $display("FAIL reset_mem_a got %h want 0", bus.mem_a); end
    n_checks++; if (bus.mem_wd !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wd got %h want 0", bus.mem_wd); end
    n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got %0b want 0", bus.mem_we); end
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL idle_req_ready got %0b want 1", bus.req_ready); end
    $display("test_reset: outputs checked in and after reset");
  endtask

  task automatic test_loads();
    logic [1:0]  sz  [6] = '{2'd2, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0};
    logic        un  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] ad  [6] = '{32'h0C, 32'h0E, 32'h0E, 32'h0E, 32'h0C, 32'h0F};
    logic [31:0] exp [6] = '{32'h8899AABB, 32'hFFFFFF99, 32'h00000099, 32'hFFFF8899, 32'h0000AABB, 32'hFFFFFF88};
    for (int i = 0; i < 6; i++) begin
      run_txn(1'b0, sz[i], un[i], ad[i], $urandom, 0);
      $display("load size=%0d uns=%0b addr=%h rdata=%h err=%0b lat=%0d", sz[i], un[i], ad[i], t_rdata, t_err, t_lat);
      n_checks++; if (t_rdata !== exp[i]) begin n_fail++; $display("FAIL load%0d_rdata got %h want %h", i, t_rdata, exp[i]); end
      n_checks++; if (t_err !== 1'b0) begin n_fail++; $display("FAIL load%0d_err got %0b want 0", i, t_err); end
      n_checks++; if (t_lat != 2) begin n_fail++; $display("FAIL load%0d_latency got %0d want 2", i, t_lat); end
      n_checks++; if (t_nwr != 0) begin n_fail++; $display("FAIL load%0d_mem_we got %0d writes want 0", i, t_nwr); end
    end
  endtask

  task automatic test_substores();
    model(1'b1, 2'd0, 1'b0, 32'h0D, 32'h12345677);
    run_txn(1'b1, 2'd0, 1'b0, 32'h0D, 32'h12345677, 0);
    $display("SB 0x0D wd=%h writes=%0d at=%0d lat=%0d", t_wdata, t_nwr, t_wcyc, t_lat);
    n_checks++; if (t_nwr != 1 || t_wcyc != 2) begin n_fail++; $display("FAIL sb_write_pulse got %0d writes at %0d want 1 at 2", t_nwr, t_wcyc); end
    n_checks++; if (t_wdata !== 32'h889977BB) begin n_fail++; $display("FAIL sb_mem_wd got %h want 889977bb", t_wdata); end
    n_checks++; if (t_lat != 3 || t_rdata !== 32'h0 || t_err !== 1'b0) begin n_fail++; $display("FAIL sb_resp got lat=%0d rdata=%h err=%0b want 3/0/0", t_lat, t_rdata, t_err); end
    model(1'b1, 2'd1, 1'b0, 32'h0E, 32'hFFFFCAFE);
    run_txn(1'b1, 2'd1, 1'b0, 32'h0E, 32'hFFFFCAFE, 0);
    $display("SH 0x0E wd=%h writes=%0d lat=%0d", t_wdata, t_nwr, t_lat);
    n_checks++; if (t_wdata !== 32'hCAFE77BB || t_nwr != 1) begin n_fail++; $display("FAIL sh_mem_wd got %h x%0d want cafe77bb x1", t_wdata, t_nwr); end
    n_checks++; if (tb_mem[3] !== 32'hCAFE77BB) begin n_fail++; $display("FAIL sh_word3 got %h want cafe77bb", tb_mem[3]); end
    model(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    run_txn(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0);
    $display("SW 0x10 wd=%h writes=%0d at=%0d lat=%0d", t_wdata, t_nwr, t_wcyc, t_lat);
    n_checks++; if (t_nwr != 1 || t_wcyc != 1 || t_lat != 2) begin n_fail++; $display("FAIL sw_timing got %0d writes at %0d lat %0d want 1/1/2", t_nwr, t_wcyc, t_lat); end
    n_checks++; if (tb_mem[4] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_word4 got %h want deadbeef", tb_mem[4]); end
  endtask

  task automatic test_errors();
    logic        we [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [1:0]  sz [4] = '{2'd1, 2'd2, 2'd3, 2'd2};
    logic [31:0] ad [4] = '{32'h0F, 32'h100, 32'h0C, 32'hFFFF_FF00};
    for (int i = 0; i < 4; i++) begin
      run_txn(we[i], sz[i], 1'b0, ad[i], 32'h5555_AAAA, 0);
      $display("err req we=%0b size=%0d addr=%h err=%0b lat=%0d writes=%0d", we[i], sz[i], ad[i], t_err, t_lat, t_nwr);
      n_checks++; if (t_err !== 1'b1 || t_lat != 1) begin n_fail++; $display("FAIL err%0d_resp got err=%0b lat=%0d want 1/1", i, t_err, t_lat); end
      n_checks++; if (t_nwr != 0 || t_rdata !== 32'h0) begin n_fail++; $display("FAIL err%0d_side got writes=%0d rdata=%h want 0/0", i, t_nwr, t_rdata); end
    end
    n_checks++; if (tb_mem[3] !== 32'hCAFE77BB) begin n_fail++; $display("FAIL err_word3 got %h want cafe77bb", tb_mem[3]); end
  endtask

  task automatic test_stall_back_to_back();
    run_txn(1'b0, 2'd2, 1'b0, 32'h0C, 32'h0, 3);
    $display("LW 0x0C stalled rdata=%h held=%0b", t_rdata, t_held_ok);
    n_checks++; if (t_held_ok !== 1'b1) begin n_fail++; $display("FAIL stall_hold got %0b want 1", t_held_ok); end
    n_checks++; if (t_rdata !== 32'hCAFE77BB) begin n_fail++; $display("FAIL stall_rdata got %h want cafe77bb", t_rdata); end
    run_txn(1'b0, 2'd0, 1'b0, 32'h0C, 32'h0, 0);
    $display("LB 0x0C back-to-back ready=%0b rdata=%h lat=%0d", t_rdy_before, t_rdata, t_lat);
    n_checks++; if (t_rdy_before !== 1'b1) begin n_fail++; $display("FAIL b2b_req_ready got %0b want 1", t_rdy_before); end
    n_checks++; if (t_prev_rd !== 32'hCAFE77BB) begin n_fail++; $display("FAIL b2b_rdata_kept got %h want cafe77bb", t_prev_rd); end
    n_checks++; if (t_rdata !== 32'hFFFFFFBB || t_lat != 2) begin n_fail++; $display("FAIL b2b_lb got %h lat %0d want ffffffbb lat 2", t_rdata, t_lat); end
  endtask

  task automatic test_reset_abort();
    backdoor(3, 32'h8899AABB);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd1;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h0C; bus.req_wdata = 32'h1111;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL abort_write_cycle got mem_we=%0b want 1", bus.mem_we); end
    reset = 1'b1;
    #1;
    n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL abort_mem_we got %0b want 0", bus.mem_we); end
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0 || bus.resp_rdata !== 32'h0 || bus.req_ready !== 1'b0)
      begin n_fail++; $display("FAIL abort_resp_outputs got v=%0b e=%0b rd=%h rdy=%0b want 0", bus.resp_valid, bus.resp_err, bus.resp_rdata, bus.req_ready); end
    n_checks++; if (bus.mem_a !== 32'h0 || bus.mem_wd !== 32'h0 || bus.mem_we !== 1'b0)
      begin n_fail++; $display("FAIL abort_mem_outputs got a=%h wd=%h we=%0b want 0", bus.mem_a, bus.mem_wd, bus.mem_we); end
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL abort_idle got v=%0b rdy=%0b want 0/1", bus.resp_valid, bus.req_ready); end
    n_checks++; if (tb_mem[3] !== 32'h8899AABB) begin n_fail++; $display("FAIL abort_word3 got %h want 8899aabb", tb_mem[3]); end
    $display("reset abort: word3=%h", tb_mem[3]);
  endtask

  task automatic test_random();
    logic        we, uns;
    logic [1:0]  sz;
    logic [31:0] ad, wd;
    int          st;
    for (int i = 0; i < 150; i++) begin
      we  = 1'($urandom);
      uns = 1'($urandom);
      sz  = 2'($urandom_range(0, 3));
      ad  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 255));
      wd  = $urandom;
      st  = $urandom_range(0, 2);
      model(we, sz, uns, ad, wd);
      run_txn(we, sz, uns, ad, wd, st);
      $display("rnd%0d we=%0b size=%0d uns=%0b addr=%h wd=%h -> rdata=%h err=%0b lat=%0d writes=%0d", i, we, sz, uns, ad, wd, t_rdata, t_err, t_lat, t_nwr);
      n_checks++; if (t_rdata !== m_rdata || t_err !== m_err) begin n_fail++; $display("FAIL rnd%0d_resp got %h/%0b want %h/%0b", i, t_rdata, t_err, m_rdata, m_err); end
      n_checks++; if (t_lat != m_lat) begin n_fail++; $display("FAIL rnd%0d_latency got %0d want %0d", i, t_lat, m_lat); end
      n_checks++; if (t_nwr != m_nwr || t_wcyc != m_wcyc || (m_nwr == 1 && t_wdata !== m_wword))
        begin n_fail++; $display("FAIL rnd%0d_write got %0d at %0d wd=%h want %0d at %0d wd=%h", i, t_nwr, t_wcyc, t_wdata, m_nwr, m_wcyc, m_wword); end
      n_checks++; if (t_rdy_before !== 1'b1 || t_held_ok !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_handshake got ready=%0b held=%0b want 1/1", i, t_rdy_before, t_held_ok); end
    end
    @(negedge clk);
    for (int w = 0; w < 64; w++) begin
      n_checks++; if (tb_mem[w] !== ref_mem[w]) begin n_fail++; $display("FAIL rnd_mem%0d got %h want %h", w, tb_mem[w], ref_mem[w]); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bd_we = 1'b0; bd_idx = '0; bd_data = '0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 64; i++) backdoor(i, $urandom);
    test_reset();
    backdoor(3, 32'h8899AABB);
    test_loads();
    test_substores();
    test_errors();
    test_stall_back_to_back();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
